// File: rtl/clks_alot_p.sv
// Shared types for the clock-recovery block: rate width, half-rate limit
// bundle, recovery sequencer state encoding and run-length counter widths.
package clks_alot_p;

  localparam int COUNTER_WIDTH = 16;

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0] max_half_rate;
    logic [COUNTER_WIDTH-1:0] min_half_rate;
  } half_rate_limits_s;

  typedef enum logic [2:0] {
    RS_IDLE    = 3'd0,
    RS_CLEAR   = 3'd1,
    RS_ACQUIRE = 3'd2,
    RS_LOCKED  = 3'd3,
    RS_FAULT   = 3'd4
  } recovery_state_e;

  // Default sequencer tuning, mirrored by the top-level parameter defaults.
  localparam int LOCK_COUNT_DEF     = 8;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  // Width needed to hold 0..terminal inclusive (saturating counters stop there).
  function automatic int run_len_w(input int terminal);
    return (terminal < 1) ? 1 : $clog2(terminal + 1);
  endfunction

  localparam int LOCK_CNT_W = run_len_w(LOCK_COUNT_DEF);
  localparam int TIMEOUT_W  = run_len_w(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/run_length_counter.sv
// Saturating run-length counter: clear has priority over increment, the
// count stops at TERMINAL, and hit_o flags the increment that lands on
// TERMINAL so the caller can act on that same clock edge.
module run_length_counter
  import clks_alot_p::*;
#(
  parameter int TERMINAL = 8,
  parameter int W        = run_len_w(TERMINAL)
) (
  input  logic clk,
  input  logic async_rst,
  input  logic clk_en,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [W-1:0] TERM = W'(TERMINAL);
  localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: clear wins, otherwise count up until saturated at TERMINAL.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != TERM)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, advanced only on enabled cycles.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      count_q <= '0;
    end else if (clk_en) begin
      count_q <= count_d;
    end
  end

  assign hit_o = inc_i & ~clr_i & (count_q == LAST);

endmodule

// File: rtl/recovery_sequencer.sv
// Recovery sequencer: walks one half_rate_recovery instance through
// IDLE -> CLEAR -> ACQUIRE -> LOCKED, with relock on loss and FAULT on a
// dead input. Config is shadowed on every start so the datapath sees a
// stable setup. Optional macro RECOVERY_SEQ_AUTO_RETRY_EN makes FAULT retry
// automatically after RETRY_DELAY enabled cycles instead of being sticky.
module recovery_sequencer
  import clks_alot_p::*;
#(
  parameter int LOCK_COUNT     = 8,
  parameter int LOSS_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RETRY_DELAY    = 256
) (
  input  logic                     clk,
  input  logic                     async_rst,
  input  logic                     clk_en,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     polarity_en_cfg_i,
  input  logic                     polarity_cfg_i,
  input  half_rate_limits_s        half_rate_limits_cfg_i,
  input  logic                     sense_event_i,
  input  logic                     over_frequency_violation_i,
  input  logic                     under_frequency_violation_i,
  input  logic [COUNTER_WIDTH-1:0] current_rate_i,
  output logic                     recovery_en_o,
  output logic                     clear_state_o,
  output logic                     polarity_en_o,
  output logic                     polarity_o,
  output half_rate_limits_s        half_rate_limits_o,
  output logic [2:0]               state_o,
  output logic                     locked_o,
  output logic                     lost_o,
  output logic                     fault_o,
  output logic [COUNTER_WIDTH-1:0] locked_rate_o
);

`ifdef RECOVERY_SEQ_AUTO_RETRY_EN
  localparam logic AUTO_RETRY = 1'b1;
`else
  localparam logic AUTO_RETRY = 1'b0;
`endif

  recovery_state_e            state_d, state_q;
  logic                       recovery_en_d, recovery_en_q;
  logic                       clear_state_d, clear_state_q;
  logic                       locked_d, locked_q;
  logic                       lost_d, lost_q;
  logic                       fault_d, fault_q;
  logic                       polarity_en_d, polarity_en_q;
  logic                       polarity_d, polarity_q;
  half_rate_limits_s          limits_d, limits_q;
  logic [COUNTER_WIDTH-1:0]   locked_rate_d, locked_rate_q;

  logic good_ev, bad_ev;
  logic good_clr, bad_clr, timeout_clr, retry_clr;
  logic lock_hit, loss_hit, timeout_hit, retry_hit;
  logic timeout_active;

  // Both violation flags together still make a single bad event; flags
  // without a sense event carry no information and are ignored.
  assign good_ev = sense_event_i & ~(over_frequency_violation_i | under_frequency_violation_i);
  assign bad_ev  = sense_event_i &  (over_frequency_violation_i | under_frequency_violation_i);

  // Any stop or (re)start wipes every run length; each counter also idles
  // at zero outside the state that owns it, which covers the CLEAR reset.
  assign timeout_active = (state_q == RS_ACQUIRE) || (state_q == RS_LOCKED);
  assign good_clr    = stop_i | start_i | (state_q != RS_ACQUIRE) | bad_ev;
  assign bad_clr     = stop_i | start_i | (state_q != RS_LOCKED)  | good_ev;
  assign timeout_clr = stop_i | start_i | ~timeout_active | sense_event_i;
  assign retry_clr   = stop_i | start_i | (state_q != RS_FAULT);

  run_length_counter #(.TERMINAL(LOCK_COUNT)) u_good_cnt (
    .clk       (clk),
    .async_rst (async_rst),
    .clk_en    (clk_en),
    .clr_i     (good_clr),
    .inc_i     (good_ev),
    .hit_o     (lock_hit)
  );

  run_length_counter #(.TERMINAL(LOSS_COUNT)) u_bad_cnt (
    .clk       (clk),
    .async_rst (async_rst),
    .clk_en    (clk_en),
    .clr_i     (bad_clr),
    .inc_i     (bad_ev),
    .hit_o     (loss_hit)
  );

  run_length_counter #(.TERMINAL(TIMEOUT_CYCLES)) u_timeout_cnt (
    .clk       (clk),
    .async_rst (async_rst),
    .clk_en    (clk_en),
    .clr_i     (timeout_clr),
    .inc_i     (1'b1),
    .hit_o     (timeout_hit)
  );

  run_length_counter #(.TERMINAL(RETRY_DELAY)) u_retry_cnt (
    .clk       (clk),
    .async_rst (async_rst),
    .clk_en    (clk_en),
    .clr_i     (retry_clr),
    .inc_i     (AUTO_RETRY),
    .hit_o     (retry_hit)
  );

  // Next state and registered-output values; stop beats start beats phase logic.
  always_comb begin
    state_d       = state_q;
    polarity_en_d = polarity_en_q;
    polarity_d    = polarity_q;
    limits_d      = limits_q;
    locked_rate_d = locked_rate_q;
    lost_d        = 1'b0;

    if (stop_i) begin
      state_d = RS_IDLE;
    end else if (start_i) begin
      state_d       = RS_CLEAR;
      polarity_en_d = polarity_en_cfg_i;
      polarity_d    = polarity_cfg_i;
      limits_d      = half_rate_limits_cfg_i;
    end else begin
      case (state_q)
        RS_IDLE: begin
          state_d = RS_IDLE;
        end
        RS_CLEAR: begin
          state_d = RS_ACQUIRE;
        end
        RS_ACQUIRE: begin
          if (timeout_hit) begin
            state_d = RS_FAULT;
          end else if (lock_hit) begin
            state_d       = RS_LOCKED;
            locked_rate_d = current_rate_i;
          end
        end
        RS_LOCKED: begin
          if (timeout_hit) begin
            state_d = RS_FAULT;
          end else if (loss_hit) begin
            state_d = RS_CLEAR;
            lost_d  = 1'b1;
          end else if (good_ev) begin
            locked_rate_d = current_rate_i;
          end
        end
        RS_FAULT: begin
          if (AUTO_RETRY && retry_hit) begin
            state_d = RS_CLEAR;
          end
        end
        default: begin
          state_d = RS_IDLE;
        end
      endcase
    end

    recovery_en_d = (state_d == RS_CLEAR) || (state_d == RS_ACQUIRE) || (state_d == RS_LOCKED);
    clear_state_d = (state_d == RS_CLEAR);
    locked_d      = (state_d == RS_LOCKED);
    fault_d       = (state_d == RS_FAULT);
  end

  // Sequencer state, shadow config and status outputs, all on enabled cycles.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q       <= RS_IDLE;
      recovery_en_q <= 1'b0;
      clear_state_q <= 1'b0;
      locked_q      <= 1'b0;
      lost_q        <= 1'b0;
      fault_q       <= 1'b0;
      polarity_en_q <= 1'b0;
      polarity_q    <= 1'b0;
      limits_q      <= '0;
      locked_rate_q <= '0;
    end else if (clk_en) begin
      state_q       <= state_d;
      recovery_en_q <= recovery_en_d;
      clear_state_q <= clear_state_d;
      locked_q      <= locked_d;
      lost_q        <= lost_d;
      fault_q       <= fault_d;
      polarity_en_q <= polarity_en_d;
      polarity_q    <= polarity_d;
      limits_q      <= limits_d;
      locked_rate_q <= locked_rate_d;
    end
  end

  assign recovery_en_o      = recovery_en_q;
  assign clear_state_o      = clear_state_q;
  assign polarity_en_o      = polarity_en_q;
  assign polarity_o         = polarity_q;
  assign half_rate_limits_o = limits_q;
  assign state_o            = state_q;
  assign locked_o           = locked_q;
  assign lost_o             = lost_q;
  assign fault_o            = fault_q;
  assign locked_rate_o      = locked_rate_q;

endmodule

// File: tb/tb_recovery_sequencer.sv
// Directed bench for recovery_sequencer with default parameters.
module tb_recovery_sequencer;
  import clks_alot_p::*;

  logic clk = 1'b0;
  logic async_rst, clk_en, start_i, stop_i;
  logic pol_en_cfg, pol_cfg, sense, over_v, under_v;
  half_rate_limits_s        limits_cfg;
  logic [COUNTER_WIDTH-1:0] rate;

  logic                     recovery_en_o, clear_state_o, polarity_en_o, polarity_o;
  half_rate_limits_s        half_rate_limits_o;
  logic [2:0]               state_o;
  logic                     locked_o, lost_o, fault_o;
  logic [COUNTER_WIDTH-1:0] locked_rate_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  recovery_sequencer dut (
    .clk                         (clk),
    .async_rst                   (async_rst),
    .clk_en                      (clk_en),
    .start_i                     (start_i),
    .stop_i                      (stop_i),
    .polarity_en_cfg_i           (pol_en_cfg),
    .polarity_cfg_i              (pol_cfg),
    .half_rate_limits_cfg_i      (limits_cfg),
    .sense_event_i               (sense),
    .over_frequency_violation_i  (over_v),
    .under_frequency_violation_i (under_v),
    .current_rate_i              (rate),
    .recovery_en_o               (recovery_en_o),
    .clear_state_o               (clear_state_o),
    .polarity_en_o               (polarity_en_o),
    .polarity_o                  (polarity_o),
    .half_rate_limits_o          (half_rate_limits_o),
    .state_o                     (state_o),
    .locked_o                    (locked_o),
    .lost_o                      (lost_o),
    .fault_o                     (fault_o),
    .locked_rate_o               (locked_rate_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic s, input logic o, input logic u);
    sense = s; over_v = o; under_v = u;
    step();
    sense = 1'b0; over_v = 1'b0; under_v = 1'b0;
  endtask

  task automatic chk_st(input string tag, input logic [2:0] exp_state);
    chk(tag, 32'(state_o), 32'(exp_state));
  endtask

  initial begin
    async_rst = 1'b1; clk_en = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    pol_en_cfg = 1'b0; pol_cfg = 1'b0; sense = 1'b0; over_v = 1'b0; under_v = 1'b0;
    limits_cfg = '0; rate = '0;

    // Reset state
    #3;
    chk_st("rst_state", 3'd0);
    chk("rst_outs", {27'b0, recovery_en_o, clear_state_o, locked_o, lost_o, fault_o}, 32'h0);
    chk("rst_shadow", {30'b0, polarity_en_o, polarity_o}, 32'h0);
    chk("rst_limits", 32'(half_rate_limits_o), 32'h0);
    chk("rst_rate", 32'(locked_rate_o), 32'h0);
    step();
    async_rst = 1'b0;
    step();
    chk_st("idle_after_rst", 3'd0);

    // clk_en low: start must not be taken
    pol_en_cfg = 1'b1; pol_cfg = 1'b1;
    limits_cfg.max_half_rate = 16'h0080; limits_cfg.min_half_rate = 16'h0020;
    start_i = 1'b1; clk_en = 1'b0;
    step();
    chk_st("clken_hold", 3'd0);

    // Start: CLEAR for one cycle with config captured
    clk_en = 1'b1;
    step();
    start_i = 1'b0;
    chk_st("start_clear", 3'd1);
    chk("clear_pulse", {30'b0, clear_state_o, recovery_en_o}, 32'h3);
    chk("shadow_pol", {30'b0, polarity_en_o, polarity_o}, 32'h3);
    chk("shadow_lim", 32'(half_rate_limits_o), 32'h0080_0020);
    pol_en_cfg = 1'b0; pol_cfg = 1'b0; limits_cfg = 32'hFFFF_FFFF;
    step();
    chk_st("acquire", 3'd2);
    chk("acq_en_clr", {30'b0, clear_state_o, recovery_en_o}, 32'h1);
    chk("cfg_ignored", {30'b0, polarity_en_o, polarity_o}, 32'h3);

    // 8 good events lock, capturing 0x40
    rate = 16'h0040;
    for (int i = 0; i < 7; i++) ev(1'b1, 1'b0, 1'b0);
    chk_st("acq_7good", 3'd2);
    ev(1'b1, 1'b0, 1'b0);
    chk_st("locked_8good", 3'd3);
    chk("locked_o", 32'(locked_o), 32'h1);
    chk("lock_rate", 32'(locked_rate_o), 32'h40);

    // 4 bad events in LOCKED: loss, rate held
    rate = 16'h0055;
    ev(1'b1, 1'b1, 1'b1);
    ev(1'b1, 1'b0, 1'b1);
    ev(1'b1, 1'b1, 1'b0);
    chk_st("locked_3bad", 3'd3);
    chk("rate_hold_bad", 32'(locked_rate_o), 32'h40);
    ev(1'b1, 1'b1, 1'b0);
    chk_st("loss_clear", 3'd1);
    chk("lost_pulse", {29'b0, lost_o, locked_o, clear_state_o}, 32'h5);
    chk("loss_rate", 32'(locked_rate_o), 32'h40);
    step();
    chk_st("reacquire", 3'd2);
    chk("lost_gone", 32'(lost_o), 32'h0);

    // 7 good, 1 bad, 4 good, ignored violation, 4 good: lock only at the end
    rate = 16'h0066;
    for (int i = 0; i < 7; i++) ev(1'b1, 1'b0, 1'b0);
    ev(1'b1, 1'b0, 1'b1);
    chk_st("acq_after_bad", 3'd2);
    for (int i = 0; i < 4; i++) ev(1'b1, 1'b0, 1'b0);
    ev(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) ev(1'b1, 1'b0, 1'b0);
    chk_st("acq_14good", 3'd2);
    ev(1'b1, 1'b0, 1'b0);
    chk_st("locked_15good", 3'd3);
    chk("relock_rate", 32'(locked_rate_o), 32'h66);

    // bad, bad, good, bad, bad, bad: no loss
    ev(1'b1, 1'b1, 1'b0);
    ev(1'b1, 1'b1, 1'b0);
    rate = 16'h0077;
    ev(1'b1, 1'b0, 1'b0);
    chk("good_updates_rate", 32'(locked_rate_o), 32'h77);
    rate = 16'h0088;
    for (int i = 0; i < 3; i++) ev(1'b1, 1'b0, 1'b1);
    chk_st("no_loss", 3'd3);
    chk("no_lost", {30'b0, lost_o, locked_o}, 32'h1);

    // stop with start in LOCKED: IDLE
    stop_i = 1'b1; start_i = 1'b1;
    step();
    stop_i = 1'b0; start_i = 1'b0;
    chk_st("stop_idle", 3'd0);
    chk("stop_outs", {28'b0, recovery_en_o, clear_state_o, locked_o, fault_o}, 32'h0);

    // Timeout: 1024 silent cycles in ACQUIRE
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    chk_st("to_acq", 3'd2);
    repeat (1023) step();
    chk_st("to_before", 3'd2);
    step();
    chk_st("to_fault", 3'd4);
    chk("fault_outs", {29'b0, fault_o, recovery_en_o, locked_o}, 32'h4);
`ifdef RECOVERY_SEQ_AUTO_RETRY_EN
    repeat (255) step();
    chk_st("retry_wait", 3'd4);
    step();
    chk_st("retry_clear", 3'd1);
    chk("retry_shadow", 32'(half_rate_limits_o), 32'hFFFF_FFFF);
`else
    repeat (300) step();
    chk_st("fault_sticky", 3'd4);
    chk("fault_sticky_o", 32'(fault_o), 32'h1);
`endif

    // Restart with new config, then async reset mid-ACQUIRE
    pol_en_cfg = 1'b0; pol_cfg = 1'b1; limits_cfg = 32'h1234_0567;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk_st("restart_clear", 3'd1);
    chk("restart_shadow", 32'(half_rate_limits_o), 32'h1234_0567);
    chk("restart_pol", {30'b0, polarity_en_o, polarity_o}, 32'h1);
    step();
    for (int i = 0; i < 3; i++) ev(1'b1, 1'b0, 1'b0);
    chk_st("pre_arst_acq", 3'd2);
    #2 async_rst = 1'b1;
    #1;
    chk_st("arst_state", 3'd0);
    chk("arst_outs", {25'b0, recovery_en_o, clear_state_o, locked_o, lost_o, fault_o,
                      polarity_en_o, polarity_o}, 32'h0);
    chk("arst_rate", 32'(locked_rate_o), 32'h0);
    chk("arst_limits", 32'(half_rate_limits_o), 32'h0);
    step();
    async_rst = 1'b0;
    step();
    chk_st("post_arst_idle", 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
